cmd_sequencer: RTL

- Executes the command frames produced by cmd_manager (cmd, arg1, arg2, crc, frame_finished) against the cart memory bus.
- Checks each frame's CRC-8, decodes the command, maintains a 24-bit SNES address pointer and runs single-byte read/write transactions over a req/ack bus.
- Returns a one-byte response for the SPI return path.
- Sits between cmd_manager and the cart SRAM/ROM arbiter.

---
 rtl/cmd_seq_pkg.sv | 37 +++
 rtl/crc8_calc.sv | 18 +
 rtl/cmd_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: shared definitions for the command sequencer.
//   - command opcodes, response codes, FSM state enumeration
//   - CRC-8 polynomial and a single-byte CRC-8 update function
//     (poly 0x07, MSB-first, no reflection, no final xor)
package cmd_seq_pkg;

  localparam logic [7:0] CRC8_POLY   = 8'h07;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_SET_HI   = 8'h01;
  localparam logic [7:0] OP_SET_LO   = 8'h02;
  localparam logic [7:0] OP_WRITE    = 8'h03;
  localparam logic [7:0] OP_READ     = 8'h04;

  localparam logic [1:0] RC_OK       = 2'd0;
  localparam logic [1:0] RC_CRC_ERR  = 2'd1;
  localparam logic [1:0] RC_UNK_CMD  = 2'd2;
  localparam logic [1:0] RC_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHECK    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_RESPOND  = 2'd3
  } state_t;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_calc.sv
// crc8_calc: combinational CRC-8 over three bytes, first byte shifted in first.
// Ports:
//   byte0..byte2 in  8  message bytes (cmd, arg1, arg2)
//   crc_out      out 8  CRC-8 of the three bytes, init 0x00
module crc8_calc
  import cmd_seq_pkg::*;
(
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic [7:0] byte2,
  output logic [7:0] crc_out
);

  always_comb begin
    crc_out = crc8_byte(crc8_byte(crc8_byte(8'h00, byte0), byte1), byte2);
  end

endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: executes cmd_manager frames against the cart memory bus.
// A frame is latched on the rising edge of frame_finished (when idle and en=1),
// its CRC-8 is checked, the command decoded, and a single-byte read/write is run
// over a req/ack bus using a 24-bit address pointer. Every frame produces one
// resp_valid strobe with resp_byte/resp_code.
// Optional build macro: CMD_SEQ_STATS_EN adds frame_count / err_count outputs.
// Ports:
//   clk, reset (async, active-low)
//   en, cmd, arg1, arg2, crc, frame_finished   frame input side
//   mem_req, mem_we, mem_addr, mem_wdata,
//   mem_rdata, mem_ack                         memory bus
//   resp_byte, resp_code, resp_valid           response side
//   busy, overrun                              status
//   frame_count, err_count                     statistics (CMD_SEQ_STATS_EN only)
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [7:0]        cmd,
  input  logic [7:0]        arg1,
  input  logic [7:0]        arg2,
  input  logic [7:0]        crc,
  input  logic              frame_finished,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        resp_byte,
  output logic [1:0]        resp_code,
  output logic              resp_valid,
  output logic              busy,
`ifdef CMD_SEQ_STATS_EN
  output logic [15:0]       frame_count,
  output logic [15:0]       err_count,
`endif
  output logic              overrun
);

  // Last counter value before the wait is abandoned.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic               frame_finished_p1;
  logic               frame_edge;
  logic [7:0]         cmd_q, arg1_q, arg2_q, crc_q;
  logic [7:0]         cmd_d, arg1_d, arg2_d, crc_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [7:0]         resp_byte_q, resp_byte_d;
  logic [1:0]         resp_code_q, resp_code_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               overrun_q, overrun_d;
  logic               accept;
  logic [7:0]         crc_calc;

  assign frame_edge = frame_finished & ~frame_finished_p1;

  crc8_calc u_crc (
    .byte0   (cmd_q),
    .byte1   (arg1_q),
    .byte2   (arg2_q),
    .crc_out (crc_calc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      frame_finished_p1 <= 1'b0;
      cmd_q             <= '0;
      arg1_q            <= '0;
      arg2_q            <= '0;
      crc_q             <= '0;
      ptr_q             <= '0;
      resp_byte_q       <= '0;
      resp_code_q       <= '0;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_wdata_q       <= '0;
      cnt_q             <= '0;
      overrun_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      frame_finished_p1 <= frame_finished;
      cmd_q             <= cmd_d;
      arg1_q            <= arg1_d;
      arg2_q            <= arg2_d;
      crc_q             <= crc_d;
      ptr_q             <= ptr_d;
      resp_byte_q       <= resp_byte_d;
      resp_code_q       <= resp_code_d;
      mem_req_q         <= mem_req_d;
      mem_we_q          <= mem_we_d;
      mem_wdata_q       <= mem_wdata_d;
      cnt_q             <= cnt_d;
      overrun_q         <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    arg1_d      = arg1_q;
    arg2_d      = arg2_q;
    crc_d       = crc_q;
    ptr_d       = ptr_q;
    resp_byte_d = resp_byte_q;
    resp_code_d = resp_code_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    // Any frame edge outside IDLE is a dropped frame.
    overrun_d   = overrun_q | (frame_edge & (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (frame_edge && en) begin
          cmd_d   = cmd;
          arg1_d  = arg1;
          arg2_d  = arg2;
          crc_d   = crc;
          accept  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (crc_calc != crc_q) begin
          resp_code_d = RC_CRC_ERR;
          resp_byte_d = crc_calc;
          state_d     = S_RESPOND;
        end else begin
          case (cmd_q)
            OP_NOP: begin
              resp_code_d = RC_OK;
              resp_byte_d = 8'h00;
              state_d     = S_RESPOND;
            end
            OP_SET_HI: begin
              ptr_d[ADDR_W-1 -: 8] = arg2_q;
              resp_code_d = RC_OK;
              resp_byte_d = arg2_q;
              state_d     = S_RESPOND;
            end
            OP_SET_LO: begin
              ptr_d[15:0] = {arg1_q, arg2_q};
              resp_code_d = RC_OK;
              resp_byte_d = arg2_q;
              state_d     = S_RESPOND;
            end
            OP_WRITE: begin
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_wdata_d = arg1_q;
              cnt_d       = '0;
              state_d     = S_WAIT_ACK;
            end
            OP_READ: begin
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              cnt_d       = '0;
              state_d     = S_WAIT_ACK;
            end
            default: begin
              resp_code_d = RC_UNK_CMD;
              resp_byte_d = cmd_q;
              state_d     = S_RESPOND;
            end
          endcase
        end
      end

      S_WAIT_ACK: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          resp_code_d = RC_OK;
          resp_byte_d = mem_we_q ? arg1_q : mem_rdata;
          if (arg2_q[0]) begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
          state_d     = S_RESPOND;
        end else if (cnt_q == TMO_LAST) begin
          mem_req_d   = 1'b0;
          resp_code_d = RC_TIMEOUT;
          resp_byte_d = 8'hFF;
          state_d     = S_RESPOND;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RESPOND: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef CMD_SEQ_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (accept && (frame_count != 16'hFFFF)) begin
        frame_count <= frame_count + 16'd1;
      end
      // RESPOND lasts one cycle, so each response is counted once.
      if ((state_q == S_RESPOND) && (resp_code_q != RC_OK) && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = ptr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_byte  = resp_byte_q;
  assign resp_code  = resp_code_q;
  assign resp_valid = (state_q == S_RESPOND);
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;

endmodule
